// File: rtl/ysyx_24090013_memarb_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter: FSM state encoding,
// owner identifiers and grant bit positions.
package ysyx_24090013_memarb_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   localparam logic OWN_IFU = 1'b0;
   localparam logic OWN_LSU = 1'b1;

   // Bit positions inside the one-hot grant vector.
   localparam int GNT_IFU = 0;
   localparam int GNT_LSU = 1;

endpackage

// File: rtl/ysyx_24090013_arb_pick.sv
// Combinational 2-way picker between IFU and LSU requests.
// Build option: YSYX_24090013_ARB_RR_EN selects round-robin on collisions;
// when undefined the LSU always wins a collision and last_grant is ignored.
module ysyx_24090013_arb_pick
   import ysyx_24090013_memarb_pkg::*;
(
   input  logic       ifu_valid,
   input  logic       lsu_valid,
   input  logic       last_grant,
   output logic [1:0] grant
);

`ifdef YSYX_24090013_ARB_RR_EN
   // On a collision the requester that did not win last time gets the port.
   always_comb begin
      grant = 2'b00;
      if (ifu_valid && lsu_valid) begin
         if (last_grant == OWN_IFU) grant[GNT_LSU] = 1'b1;
         else                       grant[GNT_IFU] = 1'b1;
      end else begin
         grant[GNT_IFU] = ifu_valid;
         grant[GNT_LSU] = lsu_valid;
      end
   end
`else
   logic unused_last_grant;
   assign unused_last_grant = last_grant;

   // Fixed priority: data accesses beat instruction fetch.
   always_comb begin
      grant = 2'b00;
      grant[GNT_LSU] = lsu_valid;
      grant[GNT_IFU] = ifu_valid & ~lsu_valid;
   end
`endif

endmodule

// File: rtl/ysyx_24090013_memarb.sv
// Single-outstanding arbiter sharing one memory port between the IFU
// (read-only) and the LSU (read/write).
// Build option: YSYX_24090013_ARB_RR_EN enables round-robin collision
// resolution with a last_grant register; default is LSU-over-IFU priority.
module ysyx_24090013_memarb
   import ysyx_24090013_memarb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ifu_valid,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_ready,
   output logic                ifu_rvalid,
   output logic [DATA_W-1:0]   ifu_rdata,
   input  logic                lsu_valid,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic                lsu_wen,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_ready,
   output logic                lsu_rvalid,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_resp_valid,
   input  logic [DATA_W-1:0]   mem_resp_data
);

   state_t     state;
   logic       owner;
   logic       last_grant;
   logic [1:0] grant;

   ysyx_24090013_arb_pick u_pick (
      .ifu_valid  (ifu_valid),
      .lsu_valid  (lsu_valid),
      .last_grant (last_grant),
      .grant      (grant)
   );

   // Accept pulses are combinational in IDLE and suppressed while in reset.
   assign ifu_ready = ~rst & (state == S_IDLE) & grant[GNT_IFU];
   assign lsu_ready = ~rst & (state == S_IDLE) & grant[GNT_LSU];

`ifdef YSYX_24090013_ARB_RR_EN
   // Remember who won the most recent accept for collision fairness.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= OWN_IFU;
      end else if (state == S_IDLE && grant != 2'b00) begin
         last_grant <= grant[GNT_LSU];
      end
   end
`else
   assign last_grant = OWN_IFU;
`endif

   // Transaction FSM: accept, issue to memory, wait for response, pulse rvalid.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         owner         <= OWN_IFU;
         mem_req_valid <= 1'b0;
         mem_addr      <= '0;
         mem_wen       <= 1'b0;
         mem_wdata     <= '0;
         mem_wmask     <= '0;
         ifu_rvalid    <= 1'b0;
         lsu_rvalid    <= 1'b0;
         ifu_rdata     <= '0;
         lsu_rdata     <= '0;
      end else begin
         ifu_rvalid <= 1'b0;
         lsu_rvalid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (grant != 2'b00) begin
                  owner         <= grant[GNT_LSU];
                  mem_req_valid <= 1'b1;
                  state         <= S_ISSUE;
                  if (grant[GNT_LSU]) begin
                     mem_addr  <= lsu_addr;
                     mem_wen   <= lsu_wen;
                     mem_wdata <= lsu_wdata;
                     mem_wmask <= lsu_wmask;
                  end else begin
                     mem_addr  <= ifu_addr;
                     mem_wen   <= 1'b0;
                     mem_wdata <= '0;
                     mem_wmask <= '0;
                  end
               end
            end
            S_ISSUE: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (mem_resp_valid) begin
                  state <= S_RESP;
                  // Writes return an ack only; never leak memory data on them.
                  if (owner == OWN_LSU) begin
                     lsu_rvalid <= 1'b1;
                     lsu_rdata  <= mem_wen ? '0 : mem_resp_data;
                  end else begin
                     ifu_rvalid <= 1'b1;
                     ifu_rdata  <= mem_wen ? '0 : mem_resp_data;
                  end
               end
            end
            S_RESP: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_24090013_memarb.sv
// Self-checking bench for ysyx_24090013_memarb: transaction-level reference
// model compared every cycle, plus directed scenarios with literal expectations.
module tb_ysyx_24090013_memarb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ifu_valid = 1'b0;
   logic [31:0] ifu_addr = '0;
   logic        ifu_ready, ifu_rvalid;
   logic [31:0] ifu_rdata;
   logic        lsu_valid = 1'b0;
   logic [31:0] lsu_addr = '0;
   logic        lsu_wen = 1'b0;
   logic [31:0] lsu_wdata = '0;
   logic [3:0]  lsu_wmask = '0;
   logic        lsu_ready, lsu_rvalid;
   logic [31:0] lsu_rdata;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b1;
   logic [31:0] mem_addr;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_resp_data = '0;

   ysyx_24090013_memarb #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .ifu_valid(ifu_valid), .ifu_addr(ifu_addr), .ifu_ready(ifu_ready),
      .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
      .lsu_valid(lsu_valid), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
      .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_ready(lsu_ready),
      .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid),
      .mem_resp_data(mem_resp_data)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
   endtask

   // ---------------- memory responder ----------------
   int          stall_left = 0;
   int          resp_delay = 1;
   int          resp_cnt = 0;
   bit          mem_hs = 0;
   bit          spur = 0;
   logic [31:0] hs_addr = '0;
   logic [31:0] resp_addr = '0;

   function automatic logic [31:0] data_of(input logic [31:0] a);
      case (a)
         32'h8000_0000: return 32'h0000_0413;
         32'h8000_1000: return 32'h1111_2222;
         default:       return a ^ 32'h5A5A_5A5A;
      endcase
   endfunction

   always @(negedge clk) begin
      mem_hs  = mem_req_valid && mem_req_ready && !rst;
      hs_addr = mem_addr;
      if (mem_req_valid && stall_left > 0) stall_left--;
   end

   always @(posedge clk) begin
      bit fire;
      #1;
      fire = 0;
      mem_req_ready = (stall_left == 0);
      if (mem_hs) begin
         resp_cnt  = resp_delay;
         resp_addr = hs_addr;
         mem_hs    = 0;
      end
      if (resp_cnt > 0) begin
         resp_cnt--;
         if (resp_cnt == 0) fire = 1;
      end
      mem_resp_valid = fire || spur;
      mem_resp_data  = fire ? data_of(resp_addr) : (spur ? 32'hBAD0_BAD0 : 32'h0);
   end

   // ---------------- transaction-level reference model ----------------
   bit          busy = 0, issued = 0, got = 0;
   logic        own = 0;
   logic        last_g = 0;
   logic [31:0] e_addr = '0, e_wdata = '0, e_ifu_rdata = '0, e_lsu_rdata = '0;
   logic        e_wen = 0;
   logic [3:0]  e_wmask = '0;

   // 1 = LSU wins, 0 = IFU wins (meaningful only when some valid is high).
   function automatic logic winner(input logic iv, input logic lv, input logic lg);
`ifdef YSYX_24090013_ARB_RR_EN
      if (iv && lv) return ~lg;
      return lv;
`else
      return lv;
`endif
   endfunction

   always @(posedge clk) begin
      logic [31:0] rd;
      if (rst) begin
         busy = 0; issued = 0; got = 0; last_g = 0;
         e_addr = '0; e_wen = 0; e_wdata = '0; e_wmask = '0;
         e_ifu_rdata = '0; e_lsu_rdata = '0;
      end else if (!busy) begin
         if (ifu_valid || lsu_valid) begin
            own    = winner(ifu_valid, lsu_valid, last_g);
            last_g = own;
            busy   = 1;
            if (own) begin
               e_addr = lsu_addr; e_wen = lsu_wen; e_wdata = lsu_wdata; e_wmask = lsu_wmask;
            end else begin
               e_addr = ifu_addr; e_wen = 0; e_wdata = '0; e_wmask = '0;
            end
         end
      end else if (!issued) begin
         if (mem_req_ready) issued = 1;
      end else if (!got) begin
         if (mem_resp_valid) begin
            got = 1;
            rd  = e_wen ? 32'h0 : mem_resp_data;
            if (own) e_lsu_rdata = rd;
            else     e_ifu_rdata = rd;
         end
      end else begin
         busy = 0; issued = 0; got = 0;
      end
   end

   // Every-cycle comparison of all DUT outputs against the model.
   always @(negedge clk) begin
      logic acc, w;
      acc = !rst && !busy && (ifu_valid || lsu_valid);
      w   = winner(ifu_valid, lsu_valid, last_g);
      chk("ifu_ready",     ifu_ready,     acc && !w);
      chk("lsu_ready",     lsu_ready,     acc && w);
      chk("mem_req_valid", mem_req_valid, busy && !issued);
      chk("mem_addr",      mem_addr,      e_addr);
      chk("mem_wen",       mem_wen,       e_wen);
      chk("mem_wdata",     mem_wdata,     e_wdata);
      chk("mem_wmask",     mem_wmask,     e_wmask);
      chk("ifu_rvalid",    ifu_rvalid,    got && !own);
      chk("lsu_rvalid",    lsu_rvalid,    got && own);
      chk("ifu_rdata",     ifu_rdata,     e_ifu_rdata);
      chk("lsu_rdata",     lsu_rdata,     e_lsu_rdata);
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // which: 0 ifu_ready, 1 lsu_ready, 2 ifu_rvalid, 3 lsu_rvalid, 4 any ready, 5 any rvalid
   task automatic wait_for(input int which, input string name, output int t);
      bit seen;
      seen = 0;
      t = -100;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         case (which)
            0: seen = ifu_ready;
            1: seen = lsu_ready;
            2: seen = ifu_rvalid;
            3: seen = lsu_rvalid;
            4: seen = ifu_ready || lsu_ready;
            default: seen = ifu_rvalid || lsu_rvalid;
         endcase
         if (seen) t = cyc;
      end
      chk(name, seen, 1'b1);
   endtask

   task automatic collide(input bit exp_lsu, input string tag);
      int t0, t1, t2;
      bit g_lsu;
      ifu_addr = 32'h8000_0000;
      lsu_addr = 32'h8000_1000; lsu_wen = 0; lsu_wmask = '0;
      ifu_valid = 1; lsu_valid = 1;
      wait_for(4, {tag, "_first_ready"}, t0);
      g_lsu = lsu_ready;
      chk({tag, "_lsu_first"}, lsu_ready, exp_lsu);
      chk({tag, "_ifu_first"}, ifu_ready, !exp_lsu);
      tick();
      if (g_lsu) lsu_valid = 0;
      else       ifu_valid = 0;
      wait_for(4, {tag, "_second_ready"}, t1);
      chk({tag, "_gap"}, t1 - t0, 4);
      tick();
      ifu_valid = 0; lsu_valid = 0;
      wait_for(5, {tag, "_second_rvalid"}, t2);
   endtask

   initial begin
      int t0, t1, t2;
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, t2;
      int tr[3];
      tick(); tick();
      @(negedge clk);
      chk("rst_mem_req_valid", mem_req_valid, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_ifu_rvalid", ifu_rvalid, 0);
      chk("rst_lsu_rdata", lsu_rdata, 0);
      tick();
      rst = 0;

      // IFU alone, 1-cycle memory
      ifu_addr = 32'h8000_0000; ifu_valid = 1;
      wait_for(0, "t1_ifu_ready", t0);
      tick(); ifu_valid = 0;
      @(negedge clk);
      chk("t1_req_valid_t1", mem_req_valid, 1);
      chk("t1_mem_addr", mem_addr, 32'h8000_0000);
      @(negedge clk); @(negedge clk);
      chk("t1_ifu_rvalid_t3", ifu_rvalid, 1);
      chk("t1_ifu_rdata", ifu_rdata, 32'h0000_0413);
      chk("t1_latency", cyc - t0, 3);

      // collisions
      tick();
      collide(1, "c1");
      chk("c1_lsu_rdata", lsu_rdata, 32'h1111_2222);
      chk("c1_ifu_rdata", ifu_rdata, 32'h0000_0413);
      tick();
      collide(1, "c2");
      tick();
      lsu_addr = 32'h8000_1000; lsu_wen = 0; lsu_valid = 1;
      wait_for(1, "c3_pre_lsu_ready", t0);
      tick(); lsu_valid = 0;
      wait_for(3, "c3_pre_lsu_rvalid", t1);
      tick();
`ifdef YSYX_24090013_ARB_RR_EN
      collide(0, "c3");
`else
      collide(1, "c3");
`endif

      // LSU write with memory stalling 3 cycles
      tick();
      stall_left = 3;
      lsu_addr = 32'h8000_2000; lsu_wen = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
      lsu_valid = 1;
      wait_for(1, "w_lsu_ready", t0);
      tick();
      lsu_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = 4'hF;
      @(negedge clk); @(negedge clk); @(negedge clk);
      chk("w_req_valid_stalled", mem_req_valid, 1);
      chk("w_mem_wen", mem_wen, 1);
      chk("w_mem_addr", mem_addr, 32'h8000_2000);
      chk("w_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("w_mem_wmask", mem_wmask, 4'b0011);
      wait_for(3, "w_lsu_rvalid", t1);
      chk("w_lsu_rdata_zero", lsu_rdata, 0);
      chk("w_latency", t1 - t0, 6);

      // spurious responses in IDLE and ISSUE
      tick(); spur = 1;
      tick(); spur = 0;
      @(negedge clk);
      chk("s_idle_ifu_rvalid", ifu_rvalid, 0);
      @(negedge clk);
      chk("s_idle_lsu_rvalid", lsu_rvalid, 0);
      chk("s_idle_req_valid", mem_req_valid, 0);
      tick();
      stall_left = 3;
      ifu_addr = 32'h8000_0100; ifu_valid = 1;
      wait_for(0, "s_ifu_ready", t0);
      tick(); ifu_valid = 0; spur = 1;
      tick(); spur = 0;
      wait_for(2, "s_ifu_rvalid", t1);
      chk("s_ifu_rdata", ifu_rdata, 32'hDA5A_5B5A);
      chk("s_latency", t1 - t0, 6);

      // reset while waiting, late memory response
      tick();
      resp_delay = 2;
      ifu_addr = 32'h8000_0000; ifu_valid = 1;
      wait_for(0, "r_ifu_ready", t0);
      tick(); ifu_valid = 0;
      tick(); rst = 1;
      tick(); rst = 0;
      @(negedge clk);
      chk("r_req_valid", mem_req_valid, 0);
      chk("r_mem_addr", mem_addr, 0);
      chk("r_ifu_rvalid", ifu_rvalid, 0);
      chk("r_ifu_rdata", ifu_rdata, 0);
      chk("r_lsu_rdata", lsu_rdata, 0);
      @(negedge clk);
      chk("r_late_ifu_rvalid", ifu_rvalid, 0);
      @(negedge clk);
      chk("r_late_ifu_rvalid2", ifu_rvalid, 0);
      tick();
      resp_delay = 1;
      ifu_valid = 1;
      wait_for(0, "r2_ifu_ready", t0);
      tick(); ifu_valid = 0;
      wait_for(2, "r2_ifu_rvalid", t1);
      chk("r2_ifu_rdata", ifu_rdata, 32'h0000_0413);
      chk("r2_latency", t1 - t0, 3);

      // back-to-back IFU with continuous valid
      tick();
      ifu_addr = 32'h8000_0000; ifu_valid = 1;
      for (int k = 0; k < 3; k++) wait_for(0, "b_ifu_ready", tr[k]);
      chk("b_gap0", tr[1] - tr[0], 4);
      chk("b_gap1", tr[2] - tr[1], 4);
      tick(); ifu_valid = 0;
      wait_for(2, "b_ifu_rvalid", t2);

      tick(); tick(); tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
